overcurrent_guard: RTL and testbench
====================================

# overcurrent_guard

Current-fault supervisor that sits between the PWM generator and the motor direction/drive control stage. It synchronizes and debounces the two current-comparator inputs (above 1 A, below 750 mA) and applies trip/recover hysteresis. It gates the PWM stream, enforces a cool-down before each retry, and latches a lockout after repeated trips. Fault status and trip count go to the seven-segment display stage.

## Interface
- `DEB_CYC`, 1000: consecutive synchronized cycles needed to qualify a comparator level (10 µs at 100 MHz).
- `COOL_CYC`, 10_000_000: cool-down length in cycles before retry (100 ms).
- `MAX_TRIPS`, 3: trip count at which recovery goes to lockout instead of cool-down (1..3).
- `RUN_CLEAR_CYC`, 100_000_000: continuous RUN cycles that clear the trip count (1 s).

- `CLK_100MHz`  in  1  system clock.
- `RST_N`  in  1  asynchronous, active-low reset.
- `Over1`  in  1  asynchronous comparator; high = motor current > 1 A.
- `Under750`  in  1  asynchronous comparator; high = motor current < 750 mA.
- `PWM_IN`  in  1  PWM stream from the PWM block.
- `Clear`  in  1  synchronous level/pulse that releases lockout.
- `PWM_GATED`  out  1  PWM forwarded to motor control.
- `Fault`  out  1  high in TRIP, COOL or LOCK.
- `Lockout`  out  1  high in LOCK only.
- `TripCount`  out  2  trip counter, saturating at 3.

## Operation
- Both comparator inputs pass through 2-flop synchronizers. `o_s` and `u_s` are the synchronized values.
- Debouncers:
  - `over_q` asserts when `o_s` has been 1 for DEB_CYC consecutive cycles.
  - `under_q` asserts when `u_s`=1 and `o_s`=0 for DEB_CYC consecutive cycles.
  - Any miss resets that counter to 0. The counter saturates at DEB_CYC and the qualified flag stays high while the condition holds.
- State machine (encoded states RUN, TRIP, COOL, LOCK):
  - **RUN:** `PWM_GATED` follows `PWM_IN`.
    - `over_q` goes to TRIP and increments TripCount (saturating at 3).
    - RUN_CLEAR_CYC consecutive cycles in RUN with no trip clears TripCount to 0.
  - **TRIP:** `PWM_GATED`=0.
    - `under_q` goes to LOCK if TripCount ≥ MAX_TRIPS, otherwise to COOL.
  - **COOL:** `PWM_GATED`=0. The cool counter starts at 0 on entry.
    - `over_q` goes back to TRIP without incrementing TripCount.
    - Otherwise, after COOL_CYC cycles, go to RUN.
  - **LOCK:** `PWM_GATED`=0.
    - `Clear`=1 while `under_q`=1 goes to RUN and clears TripCount to 0.
    - `Clear` with `under_q`=0 is ignored.
- Priority when events coincide: `over_q` beats `under_q` in every state; `over_q` in LOCK keeps LOCK.
- `Clear` has no effect outside LOCK.
- Reset values (immediate and asynchronous on `RST_N`=0): state RUN, `PWM_GATED`=0, `Fault`=0, `Lockout`=0, `TripCount`=0. All counters and synchronizers are 0.
  - Reset mid-operation (including from LOCK) always returns to RUN with count 0.
  - After release, `PWM_GATED` follows `PWM_IN` from the first clock edge.
- Width rules: counter widths are sized with `$clog2` of each parameter plus 1; no wrap is permitted. TripCount compare is unsigned.

## Timing
- All outputs are registered.
- `PWM_GATED` = `PWM_IN` delayed one cycle in RUN.
- Trip latency: `Over1` high from sampling edge k.
  - `Fault`=1 and `PWM_GATED`=0 after edge k+2+DEB_CYC.
  - An `Over1` glitch shorter than DEB_CYC cycles causes no trip.
- Recovery latency: `under_q` rises at edge m.
  - State is COOL or LOCK after edge m+1.
  - From COOL, `PWM_GATED` resumes after edge m+1+COOL_CYC+1.
- `Fault` and `Lockout` change on the same edge as the state register.

## Test plan
Parameters for all scenarios: DEB_CYC=4, COOL_CYC=20, MAX_TRIPS=3, RUN_CLEAR_CYC=50.
- **Reset:** `RST_N`=0 mid-cycle with `PWM_IN` toggling → all outputs 0 immediately. After release, `PWM_GATED` mirrors `PWM_IN` with 1 cycle lag.
- **Glitch rejection:** `Over1` high for 3 cycles → no trip, `Fault`=0. Then `Over1` high for 4 cycles → `Fault`=1 at edge k+6, `TripCount`=1, `PWM_GATED`=0.
- **Retry:** after a trip, `Over1`=0 and `Under750`=1 for 4 cycles → COOL. After 20 cycles → RUN, `Fault`=0, PWM resumes.
- **Lockout:** three trips without 50 clean RUN cycles → `Lockout`=1, `TripCount`=3.
  - `Clear` with `Under750`=0 → stays locked.
  - `Clear` with `Under750` qualified → RUN, `TripCount`=0.
- **Count decay:** one trip, then 50 clean RUN cycles → `TripCount`=0. A new trip → `TripCount`=1.
- **Re-trip in COOL:** `Over1` qualified during COOL → TRIP, `TripCount` unchanged, cool counter restarts on the next COOL entry.

Source files
------------

// File: rtl/overcurrent_guard.sv
// Current-fault supervisor: synchronizes and debounces the over/under comparators,
// gates PWM while faulted, times the cool-down before retry and latches lockout after repeated trips.
module overcurrent_guard #(
  parameter int unsigned DEB_CYC       = 1000,
  parameter int unsigned COOL_CYC      = 10_000_000,
  parameter int unsigned MAX_TRIPS     = 3,
  parameter int unsigned RUN_CLEAR_CYC = 100_000_000
) (
  input  logic       CLK_100MHz,
  input  logic       RST_N,
  input  logic       Over1,
  input  logic       Under750,
  input  logic       PWM_IN,
  input  logic       Clear,
  output logic       PWM_GATED,
  output logic       Fault,
  output logic       Lockout,
  output logic [1:0] TripCount
);

  localparam int unsigned DW = $clog2(DEB_CYC) + 1;
  localparam int unsigned CW = $clog2(COOL_CYC) + 1;
  localparam int unsigned RW = $clog2(RUN_CLEAR_CYC) + 1;

  typedef enum logic [1:0] {RUN, TRIP, COOL, LOCK} state_t;

  state_t          state;
  logic [1:0]      o_sync;
  logic [1:0]      u_sync;
  logic            o_s;
  logic            u_s;
  logic [DW-1:0]   over_cnt;
  logic [DW-1:0]   under_cnt;
  logic            over_q;
  logic            under_q;
  logic [CW-1:0]   cool_cnt;
  logic [RW-1:0]   run_cnt;

  assign o_s = o_sync[1];
  assign u_s = u_sync[1];

  // Two-flop synchronizers for the asynchronous comparator inputs
  always_ff @(posedge CLK_100MHz or negedge RST_N) begin
    if (!RST_N) begin
      o_sync <= 2'b00;
      u_sync <= 2'b00;
    end else begin
      o_sync <= {o_sync[0], Over1};
      u_sync <= {u_sync[0], Under750};
    end
  end

  // Debouncers: the flag rises on the DEB_CYC-th consecutive qualifying cycle
  always_ff @(posedge CLK_100MHz or negedge RST_N) begin
    if (!RST_N) begin
      over_cnt  <= '0;
      under_cnt <= '0;
      over_q    <= 1'b0;
      under_q   <= 1'b0;
    end else begin
      if (o_s) begin
        if (over_cnt < DW'(DEB_CYC)) over_cnt <= over_cnt + DW'(1);
        over_q <= (over_cnt >= DW'(DEB_CYC - 1));
      end else begin
        over_cnt <= '0;
        over_q   <= 1'b0;
      end
      if (u_s && !o_s) begin
        if (under_cnt < DW'(DEB_CYC)) under_cnt <= under_cnt + DW'(1);
        under_q <= (under_cnt >= DW'(DEB_CYC - 1));
      end else begin
        under_cnt <= '0;
        under_q   <= 1'b0;
      end
    end
  end

  // Supervisor FSM; outputs are registered alongside the state they belong to
  always_ff @(posedge CLK_100MHz or negedge RST_N) begin
    if (!RST_N) begin
      state     <= RUN;
      PWM_GATED <= 1'b0;
      Fault     <= 1'b0;
      Lockout   <= 1'b0;
      TripCount <= 2'd0;
      cool_cnt  <= '0;
      run_cnt   <= '0;
    end else begin
      PWM_GATED <= 1'b0;
      cool_cnt  <= '0;
      run_cnt   <= '0;
      case (state)
        RUN: begin
          if (over_q) begin
            state <= TRIP;
            Fault <= 1'b1;
            if (TripCount != 2'd3) TripCount <= TripCount + 2'd1;
          end else begin
            PWM_GATED <= PWM_IN;
            run_cnt   <= (run_cnt < RW'(RUN_CLEAR_CYC)) ? run_cnt + RW'(1) : run_cnt;
            if (run_cnt >= RW'(RUN_CLEAR_CYC - 1)) TripCount <= 2'd0;
          end
        end
        TRIP: begin
          if (!over_q && under_q) begin
            if (TripCount >= 2'(MAX_TRIPS)) begin
              state   <= LOCK;
              Lockout <= 1'b1;
            end else begin
              state <= COOL;
            end
          end
        end
        COOL: begin
          if (over_q) begin
            state <= TRIP;
          end else if (cool_cnt == CW'(COOL_CYC)) begin
            state     <= RUN;
            Fault     <= 1'b0;
            PWM_GATED <= PWM_IN;
          end else begin
            cool_cnt <= cool_cnt + CW'(1);
          end
        end
        LOCK: begin
          // An over-current indication keeps the lock even if Clear is pressed
          if (!over_q && under_q && Clear) begin
            state     <= RUN;
            Fault     <= 1'b0;
            Lockout   <= 1'b0;
            TripCount <= 2'd0;
            PWM_GATED <= PWM_IN;
          end
        end
        default: begin
          state   <= RUN;
          Fault   <= 1'b0;
          Lockout <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_overcurrent_guard.sv
// Bench for overcurrent_guard: directed scenarios plus randomized stimulus, every cycle
// compared against a timestamp/history based model of the supervisor rules.
module tb_overcurrent_guard;

  localparam int DEB  = 4;
  localparam int COOL = 20;
  localparam int MAXT = 3;
  localparam int RC   = 50;

  localparam int M_RUN  = 0;
  localparam int M_TRIP = 1;
  localparam int M_COOL = 2;
  localparam int M_LOCK = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       over1 = 1'b0;
  logic       under750 = 1'b0;
  logic       pwm_in = 1'b0;
  logic       clear = 1'b0;
  logic       pwm_gated;
  logic       fault;
  logic       lockout;
  logic [1:0] trip_count;

  int vectors = 0;
  int errors  = 0;
  bit checking = 1'b0;

  overcurrent_guard #(
    .DEB_CYC(DEB), .COOL_CYC(COOL), .MAX_TRIPS(MAXT), .RUN_CLEAR_CYC(RC)
  ) dut (
    .CLK_100MHz(clk),
    .RST_N(rst_n),
    .Over1(over1),
    .Under750(under750),
    .PWM_IN(pwm_in),
    .Clear(clear),
    .PWM_GATED(pwm_gated),
    .Fault(fault),
    .Lockout(lockout),
    .TripCount(trip_count)
  );

  always #5 clk = ~clk;

  // Reference model: qualification from raw sample history, timing from edge timestamps
  int m_mode = M_RUN;
  int m_tc = 0;
  int m_n = 0;
  int run_since = 0;
  int cool_entry = 0;
  bit m_pwm = 1'b0;
  bit oq, uq;
  bit ho[$];
  bit hu[$];

  // ho[j] is Over1 as sampled j edges before the current one (j=0: previous edge)
  function automatic bit qual_over();
    for (int j = 2; j <= DEB + 1; j++) if (!ho[j]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit qual_under();
    for (int j = 2; j <= DEB + 1; j++) if (!hu[j] || ho[j]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_RUN; m_tc = 0; m_n = 0; run_since = 0; cool_entry = 0; m_pwm = 1'b0;
      ho = {}; hu = {};
      for (int j = 0; j < DEB + 2; j++) begin ho.push_back(1'b0); hu.push_back(1'b0); end
    end else begin
      oq = qual_over();
      uq = qual_under();
      m_n++;
      case (m_mode)
        M_RUN: begin
          if (oq) begin
            m_mode = M_TRIP;
            m_tc = (m_tc < 3) ? m_tc + 1 : 3;
          end else if (m_n - run_since >= RC) begin
            m_tc = 0;
          end
        end
        M_TRIP: begin
          if (!oq && uq) begin
            if (m_tc >= MAXT) m_mode = M_LOCK;
            else begin m_mode = M_COOL; cool_entry = m_n; end
          end
        end
        M_COOL: begin
          if (oq) m_mode = M_TRIP;
          else if (m_n - cool_entry == COOL + 1) begin m_mode = M_RUN; run_since = m_n; end
        end
        default: begin
          if (!oq && uq && clear) begin m_mode = M_RUN; m_tc = 0; run_since = m_n; end
        end
      endcase
      m_pwm = (m_mode == M_RUN) ? pwm_in : 1'b0;
      ho.push_front(over1); void'(ho.pop_back());
      hu.push_front(under750); void'(hu.pop_back());
    end
  end

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("pwm_gated", 4'(pwm_gated), 4'(m_pwm));
      chk("fault", 4'(fault), 4'(m_mode != M_RUN));
      chk("lockout", 4'(lockout), 4'(m_mode == M_LOCK));
      chk("trip_count", 4'(trip_count), 4'(m_tc));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      pwm_in = 1'($urandom);
    end
  endtask

  task automatic trip();
    over1 = 1'b1; under750 = 1'b0;
    cyc(8);
    over1 = 1'b0;
    cyc(3);
  endtask

  task automatic recover();
    under750 = 1'b1;
    cyc(8);
  endtask

  initial begin
    int len;
    #3 rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    checking = 1'b1;
    cyc(10);

    // Glitch of 3 cycles must not trip; 4 cycles trips at edge k+6
    over1 = 1'b1; cyc(3); over1 = 1'b0; cyc(10);
    chk("glitch_fault", 4'(fault), 4'd0);
    over1 = 1'b1; cyc(4); over1 = 1'b0; cyc(2);
    chk("trip_k5_fault", 4'(fault), 4'd0);
    cyc(1);
    chk("trip_k6_fault", 4'(fault), 4'd1);
    chk("trip_k6_count", 4'(trip_count), 4'd1);
    chk("trip_k6_pwm", 4'(pwm_gated), 4'd0);

    // Retry through cool-down
    recover();
    chk("cool_fault", 4'(fault), 4'd1);
    cyc(25);
    chk("retry_fault", 4'(fault), 4'd0);
    under750 = 1'b0;

    // Two more trips inside the clear window lead to lockout
    trip(); recover(); cyc(25);
    chk("second_count", 4'(trip_count), 4'd2);
    trip(); recover();
    chk("lock_lockout", 4'(lockout), 4'd1);
    chk("lock_count", 4'(trip_count), 4'd3);
    under750 = 1'b0; cyc(8);
    clear = 1'b1; cyc(3); clear = 1'b0;
    chk("clear_ignored", 4'(lockout), 4'd1);
    under750 = 1'b1; cyc(8);
    clear = 1'b1; cyc(1); clear = 1'b0;
    chk("clear_lockout", 4'(lockout), 4'd0);
    chk("clear_fault", 4'(fault), 4'd0);
    chk("clear_count", 4'(trip_count), 4'd0);

    // Count decay after a clean run window
    cyc(2);
    trip();
    chk("decay_trip_count", 4'(trip_count), 4'd1);
    recover(); cyc(25); under750 = 1'b0;
    chk("decay_pre", 4'(trip_count), 4'd1);
    cyc(52);
    chk("decay_post", 4'(trip_count), 4'd0);
    trip();
    chk("decay_new_trip", 4'(trip_count), 4'd1);

    // Re-trip while cooling keeps the count
    recover(); under750 = 1'b0;
    over1 = 1'b1; cyc(8);
    chk("cool_retrip_fault", 4'(fault), 4'd1);
    chk("cool_retrip_count", 4'(trip_count), 4'd1);
    over1 = 1'b0; cyc(3);
    recover(); cyc(25);
    chk("cool_retrip_run", 4'(fault), 4'd0);
    under750 = 1'b0;

    // Asynchronous reset out of lockout
    trip(); recover(); cyc(25); under750 = 1'b0;
    trip(); recover(); under750 = 1'b0;
    chk("relock_lockout", 4'(lockout), 4'd1);
    @(posedge clk); #2 rst_n = 1'b0; #1;
    chk("rst_pwm", 4'(pwm_gated), 4'd0);
    chk("rst_fault", 4'(fault), 4'd0);
    chk("rst_lockout", 4'(lockout), 4'd0);
    chk("rst_count", 4'(trip_count), 4'd0);
    @(negedge clk); rst_n = 1'b1;
    cyc(5);

    // Randomized segments of held comparator levels
    repeat (150) begin
      over1    = ($urandom_range(0, 4) == 0);
      under750 = 1'($urandom_range(0, 1));
      len      = $urandom_range(1, 12);
      repeat (len) begin
        clear = ($urandom_range(0, 7) == 0);
        cyc(1);
      end
      if ($urandom_range(0, 49) == 0) begin
        @(posedge clk); #2 rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
      end
    end
    clear = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
